// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Immediate extender that sits between decode and execute. The opcode in
//   the top OPC_W bits of the instruction word selects which low-order field
//   is the immediate. That field is sign- or zero-extended to DATA_W bits.
//   The result goes through a one-cycle registered stage. A two-entry skid
//   buffer lets the upstream ready be a pure register output.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   flush_i      synchronous flush, drops both buffered entries
//   ir_valid_i   instruction word valid
//   ir_i         instruction word [DATA_W]
//   zext_i       1 = zero-extend, 0 = sign-extend
//   ir_ready_o   stage accepts ir_i this cycle (registered)
//   imm_valid_o  imm_o / imm_kind_o valid
//   imm_o        extended immediate [DATA_W]
//   imm_kind_o   0 = default class, 1 = load-immediate, 2 = jump
//   imm_ready_i  consumer accepts imm_o
module imm_extend_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned OPC_W     = 4,
  parameter logic [OPC_W-1:0] OPC_J  = 4'hE,
  parameter logic [OPC_W-1:0] OPC_LI = 4'hD,
  parameter int unsigned J_IMM_W   = 28,
  parameter int unsigned LI_IMM_W  = 23,
  parameter int unsigned DEF_IMM_W = 18
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              ir_valid_i,
  input  logic [DATA_W-1:0] ir_i,
  input  logic              zext_i,
  output logic              ir_ready_o,
  output logic              imm_valid_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [1:0]        imm_kind_o,
  input  logic              imm_ready_i
);

  localparam logic [1:0] KIND_DEF = 2'd0;
  localparam logic [1:0] KIND_LI  = 2'd1;
  localparam logic [1:0] KIND_J   = 2'd2;

  // Field widths must leave the opcode untouched and be non-empty.
  if (J_IMM_W < 1 || J_IMM_W > DATA_W - OPC_W) begin : g_bad_j_w
    $error("imm_extend_pipe: J_IMM_W out of range");
  end
  if (LI_IMM_W < 1 || LI_IMM_W > DATA_W - OPC_W) begin : g_bad_li_w
    $error("imm_extend_pipe: LI_IMM_W out of range");
  end
  if (DEF_IMM_W < 1 || DEF_IMM_W > DATA_W - OPC_W) begin : g_bad_def_w
    $error("imm_extend_pipe: DEF_IMM_W out of range");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] out_imm, out_imm_n;
  logic [1:0]        out_kind, out_kind_n;
  logic [DATA_W-1:0] skid_imm, skid_imm_n;
  logic [1:0]        skid_kind, skid_kind_n;

  logic [OPC_W-1:0]  opc;
  logic [DATA_W-1:0] ext_j, ext_li, ext_def;
  logic [DATA_W-1:0] ext;
  logic [1:0]        ext_kind;
  logic              accept, take;

  // Each field is extended at its own width. The upper fill is either
  // zeros or the field's top bit, so opcode bits never leak into the result.
  always_comb begin
    opc     = ir_i[DATA_W-1 -: OPC_W];
    ext_j   = {{(DATA_W-J_IMM_W){ir_i[J_IMM_W-1] & ~zext_i}}, ir_i[J_IMM_W-1:0]};
    ext_li  = {{(DATA_W-LI_IMM_W){ir_i[LI_IMM_W-1] & ~zext_i}}, ir_i[LI_IMM_W-1:0]};
    ext_def = {{(DATA_W-DEF_IMM_W){ir_i[DEF_IMM_W-1] & ~zext_i}}, ir_i[DEF_IMM_W-1:0]};
    if (opc == OPC_J) begin
      ext      = ext_j;
      ext_kind = KIND_J;
    end else if (opc == OPC_LI) begin
      ext      = ext_li;
      ext_kind = KIND_LI;
    end else begin
      ext      = ext_def;
      ext_kind = KIND_DEF;
    end
  end

  // The handshake outputs decode only the state register. Upstream ready
  // therefore never depends combinationally on the downstream ready.
  assign ir_ready_o  = (state != FULL);
  assign imm_valid_o = (state != EMPTY);
  assign imm_o       = out_imm;
  assign imm_kind_o  = out_kind;
  assign accept      = ir_valid_i & ir_ready_o;
  assign take        = imm_valid_o & imm_ready_i;

  // Next-state and next-data logic. An emptied slot has its data zeroed,
  // so imm_o reads zero whenever imm_valid_o is low.
  always_comb begin
    state_n     = state;
    out_imm_n   = out_imm;
    out_kind_n  = out_kind;
    skid_imm_n  = skid_imm;
    skid_kind_n = skid_kind;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_n    = ONE;
          out_imm_n  = ext;
          out_kind_n = ext_kind;
        end
      end
      ONE: begin
        if (accept && take) begin
          out_imm_n  = ext;
          out_kind_n = ext_kind;
        end else if (accept) begin
          state_n     = FULL;
          skid_imm_n  = ext;
          skid_kind_n = ext_kind;
        end else if (take) begin
          state_n    = EMPTY;
          out_imm_n  = '0;
          out_kind_n = KIND_DEF;
        end
      end
      FULL: begin
        if (take) begin
          state_n     = ONE;
          out_imm_n   = skid_imm;
          out_kind_n  = skid_kind;
          skid_imm_n  = '0;
          skid_kind_n = KIND_DEF;
        end
      end
      default: begin
        state_n = EMPTY;
      end
    endcase
    if (flush_i) begin
      state_n     = EMPTY;
      out_imm_n   = '0;
      out_kind_n  = KIND_DEF;
      skid_imm_n  = '0;
      skid_kind_n = KIND_DEF;
    end
  end

  // State and data registers. Reset empties both slots immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= EMPTY;
      out_imm   <= '0;
      out_kind  <= KIND_DEF;
      skid_imm  <= '0;
      skid_kind <= KIND_DEF;
    end else begin
      state     <= state_n;
      out_imm   <= out_imm_n;
      out_kind  <= out_kind_n;
      skid_imm  <= skid_imm_n;
      skid_kind <= skid_kind_n;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
//   Directed bench for imm_extend_pipe. Inputs change and outputs are
//   sampled on the falling clock edge. All expected values are hand-computed.
module tb_imm_extend_pipe;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        ir_valid_i;
  logic [31:0] ir_i;
  logic        zext_i;
  logic        ir_ready_o;
  logic        imm_valid_o;
  logic [31:0] imm_o;
  logic [1:0]  imm_kind_o;
  logic        imm_ready_i;

  int checks;
  int errors;

  imm_extend_pipe dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .ir_valid_i  (ir_valid_i),
    .ir_i        (ir_i),
    .zext_i      (zext_i),
    .ir_ready_o  (ir_ready_o),
    .imm_valid_o (imm_valid_o),
    .imm_o       (imm_o),
    .imm_kind_o  (imm_kind_o),
    .imm_ready_i (imm_ready_i)
  );

  // 10-unit clock period.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one set of inputs and holds it until the next call.
  task automatic applyStimulus(input logic v, input logic [31:0] ir, input logic z,
                               input logic rdy, input logic fl);
    ir_valid_i  = v;
    ir_i        = ir;
    zext_i      = z;
    imm_ready_i = rdy;
    flush_i     = fl;
  endtask

  task automatic nextCycle();
    @(negedge clk_i);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_i  = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("rst_valid", {31'd0, imm_valid_o}, 32'd0);
    checkOutput("rst_imm", imm_o, 32'h0);
    checkOutput("rst_kind", {30'd0, imm_kind_o}, 32'd0);
    checkOutput("rst_ready", {31'd0, ir_ready_o}, 32'd1);
    rst_i = 1'b0;
    nextCycle();

    // Default class, sign-extended from bit 17.
    applyStimulus(1'b1, 32'h1002_0000, 1'b0, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("def_valid", {31'd0, imm_valid_o}, 32'd1);
    checkOutput("def_imm", imm_o, 32'hFFFE_0000);
    checkOutput("def_kind", {30'd0, imm_kind_o}, 32'd0);
    nextCycle();

    // Jump class (sign) followed directly by load-immediate class (zero).
    applyStimulus(1'b1, 32'hE800_0000, 1'b0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("j_imm", imm_o, 32'hF800_0000);
    checkOutput("j_kind", {30'd0, imm_kind_o}, 32'd2);
    applyStimulus(1'b1, 32'hD040_0001, 1'b1, 1'b1, 1'b0);
    nextCycle();
    checkOutput("li_imm", imm_o, 32'h0040_0001);
    checkOutput("li_kind", {30'd0, imm_kind_o}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("idle_valid", {31'd0, imm_valid_o}, 32'd0);
    checkOutput("idle_imm", imm_o, 32'h0);

    // Backpressure fills the skid buffer. Draining then preserves order.
    applyStimulus(1'b1, 32'h1000_0001, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("bp_a_imm", imm_o, 32'h1);
    checkOutput("bp_a_ready", {31'd0, ir_ready_o}, 32'd1);
    applyStimulus(1'b1, 32'h1000_0002, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("bp_full_ready", {31'd0, ir_ready_o}, 32'd0);
    checkOutput("bp_full_imm", imm_o, 32'h1);
    applyStimulus(1'b1, 32'h1000_0009, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("bp_hold_imm", imm_o, 32'h1);
    checkOutput("bp_hold_valid", {31'd0, imm_valid_o}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("bp_ready_reg", {31'd0, ir_ready_o}, 32'd0);
    nextCycle();
    checkOutput("bp_b_imm", imm_o, 32'h2);
    checkOutput("bp_b_ready", {31'd0, ir_ready_o}, 32'd1);
    nextCycle();
    checkOutput("bp_drained", {31'd0, imm_valid_o}, 32'd0);

    // Back-to-back stream: one result per cycle, in order.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h1000_0010 + 32'(i), 1'b0, 1'b1, 1'b0);
      nextCycle();
      checkOutput($sformatf("stream_%0d", i), imm_o, 32'h10 + 32'(i));
      checkOutput($sformatf("stream_rdy_%0d", i), {31'd0, ir_ready_o}, 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("stream_end", {31'd0, imm_valid_o}, 32'd0);

    // Flush while FULL, with a new word offered in the same cycle.
    applyStimulus(1'b1, 32'h1000_0003, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h1000_0004, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("fl_full", {31'd0, ir_ready_o}, 32'd0);
    applyStimulus(1'b1, 32'h1000_0005, 1'b0, 1'b1, 1'b1);
    nextCycle();
    checkOutput("fl_valid", {31'd0, imm_valid_o}, 32'd0);
    checkOutput("fl_imm", imm_o, 32'h0);
    checkOutput("fl_ready", {31'd0, ir_ready_o}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("fl_dropped", {31'd0, imm_valid_o}, 32'd0);

    // Asynchronous reset pulse between clock edges while data is held.
    applyStimulus(1'b1, 32'hE000_0007, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("ar_pre_imm", imm_o, 32'h7);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("ar_valid", {31'd0, imm_valid_o}, 32'd0);
    checkOutput("ar_imm", imm_o, 32'h0);
    checkOutput("ar_kind", {30'd0, imm_kind_o}, 32'd0);
    checkOutput("ar_ready", {31'd0, ir_ready_o}, 32'd1);
    nextCycle();
    rst_i = 1'b0;
    applyStimulus(1'b1, 32'h1000_0007, 1'b0, 1'b1, 1'b0);
    nextCycle();
    checkOutput("ar_post_valid", {31'd0, imm_valid_o}, 32'd1);
    checkOutput("ar_post_imm", imm_o, 32'h7);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
